// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback strobes for a simple datapath.
// Optional retired-instruction counter enabled by DATAPATH_SEQUENCER_RETIRED_EN.
module datapath_sequencer #(
  parameter int unsigned RETIRED_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     memReady,
  input  logic [6:0]               opcode,
  input  logic                     zero,
  output logic                     pcWrite,
  output logic                     pcSrc,
  output logic                     irWrite,
  output logic                     regWrite,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     aluSrc,
  output logic                     memToReg,
  output logic                     halted,
  output logic                     illegal,
  output logic [1:0]               aluOp,
  output logic [2:0]               state,
  output logic [RETIRED_WIDTH-1:0] retired
);

  localparam logic [2:0] st_idle      = 3'd0;
  localparam logic [2:0] st_fetch     = 3'd1;
  localparam logic [2:0] st_decode    = 3'd2;
  localparam logic [2:0] st_execute   = 3'd3;
  localparam logic [2:0] st_memory    = 3'd4;
  localparam logic [2:0] st_writeback = 3'd5;
  localparam logic [2:0] st_halt      = 3'd6;

  localparam logic [6:0] op_r      = 7'b0110011;
  localparam logic [6:0] op_i      = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_system = 7'b1110011;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [6:0] op_q;
  logic       illegal_q;
  logic       set_illegal_c;

  // State, latched opcode and sticky illegal flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= st_idle;
      op_q      <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == st_decode) begin
        op_q <= opcode;
      end
      if (set_illegal_c) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state and Moore strobes (memReady/zero qualify FETCH, MEMORY, EXECUTE)
  always_comb begin
    state_d       = state_q;
    set_illegal_c = 1'b0;
    pcWrite       = 1'b0;
    pcSrc         = 1'b0;
    irWrite       = 1'b0;
    regWrite      = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    aluSrc        = 1'b0;
    memToReg      = 1'b0;
    halted        = 1'b0;
    aluOp         = 2'b00;
    case (state_q)
      st_idle: begin
        if (start) begin
          state_d = st_fetch;
        end
      end
      st_fetch: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = st_decode;
        end
      end
      st_decode: begin
        case (opcode)
          op_r, op_i, op_load, op_store, op_branch: state_d = st_execute;
          op_system: state_d = st_halt;
          default: begin
            state_d       = st_halt;
            set_illegal_c = 1'b1;
          end
        endcase
      end
      st_execute: begin
        case (op_q)
          op_r: begin
            aluOp   = 2'b10;
            state_d = st_writeback;
          end
          op_i: begin
            aluOp   = 2'b10;
            aluSrc  = 1'b1;
            state_d = st_writeback;
          end
          op_load, op_store: begin
            aluSrc  = 1'b1;
            state_d = st_memory;
          end
          op_branch: begin
            aluOp   = 2'b01;
            pcSrc   = 1'b1;
            pcWrite = zero;
            state_d = st_fetch;
          end
          default: state_d = st_idle;
        endcase
      end
      st_memory: begin
        if (op_q == op_load) begin
          memRead = 1'b1;
          if (memReady) begin
            state_d = st_writeback;
          end
        end else if (op_q == op_store) begin
          memWrite = 1'b1;
          if (memReady) begin
            state_d = st_fetch;
          end
        end else begin
          state_d = st_idle;
        end
      end
      st_writeback: begin
        regWrite = 1'b1;
        memToReg = (op_q == op_load);
        state_d  = st_fetch;
      end
      st_halt: begin
        halted = 1'b1;
      end
      default: state_d = st_idle;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef DATAPATH_SEQUENCER_RETIRED_EN
  logic                     retire_c;
  logic [RETIRED_WIDTH-1:0] retired_q;

  // An instruction retires on its final transition back into FETCH
  assign retire_c = (state_q == st_writeback)
                  | ((state_q == st_memory) && (op_q == op_store) && memReady)
                  | ((state_q == st_execute) && (op_q == op_branch));

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire_c) begin
      retired_q <= retired_q + RETIRED_WIDTH'(1);
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule
